// File: rtl/param_paritysel_demux.sv
// Parity-select demux: one valid/ready input stream steered by sel[0] into two
// independent output FIFOs (even -> A, odd -> B). Optional stats: PARITYSEL_DEMUX_STATS_EN.

module paritysel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [WIDTH-1:0] rdata
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; an empty FIFO masks it to 0
  // at rdata, and keeping it reset-free lets synthesis map it onto plain RAM/regs.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module param_paritysel_demux #(
  parameter int WIDTH   = 8,
  parameter int T_WIDTH = WIDTH - 1,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [T_WIDTH:0] data_in,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [T_WIDTH:0] data_out_a,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [T_WIDTH:0] data_out_b
`ifdef PARITYSEL_DEMUX_STATS_EN
  ,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b,
  output logic             stall_seen
`endif
);
  logic full_a, full_b;
  logic push_a, push_b;
  logic unused_sel;

  // Only the parity bit routes; the upper select bits are intentionally ignored.
  assign unused_sel = ^sel[3:1];

  assign in_ready = sel[0] ? !full_b : !full_a;
  assign push_a   = in_valid && in_ready && !sel[0];
  assign push_b   = in_valid && in_ready &&  sel[0];

  paritysel_fifo #(.WIDTH(T_WIDTH + 1), .DEPTH(DEPTH)) u_fifo_a (
    .clk   (clk),
    .rst   (rst),
    .push  (push_a),
    .wdata (data_in),
    .pop   (a_ready),
    .valid (a_valid),
    .full  (full_a),
    .rdata (data_out_a)
  );

  paritysel_fifo #(.WIDTH(T_WIDTH + 1), .DEPTH(DEPTH)) u_fifo_b (
    .clk   (clk),
    .rst   (rst),
    .push  (push_b),
    .wdata (data_in),
    .pop   (b_ready),
    .valid (b_valid),
    .full  (full_b),
    .rdata (data_out_b)
  );

`ifdef PARITYSEL_DEMUX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a      <= '0;
      cnt_b      <= '0;
      stall_seen <= 1'b0;
    end else begin
      if (push_a) cnt_a <= cnt_a + 16'd1;
      if (push_b) cnt_b <= cnt_b + 16'd1;
      if (in_valid && !in_ready) stall_seen <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_param_paritysel_demux.sv
// Directed self-checking bench for param_paritysel_demux (WIDTH=8, DEPTH=4).
// Stats checks are built only when PARITYSEL_DEMUX_STATS_EN is defined.

module tb_param_paritysel_demux;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sel;
  logic       in_valid, in_ready;
  logic [7:0] data_in;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [7:0] data_out_a, data_out_b;
`ifdef PARITYSEL_DEMUX_STATS_EN
  logic [15:0] cnt_a, cnt_b;
  logic        stall_seen;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always #5 clk = ~clk;

  param_paritysel_demux #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .a_valid    (a_valid),
    .a_ready    (a_ready),
    .data_out_a (data_out_a),
    .b_valid    (b_valid),
    .b_ready    (b_ready),
    .data_out_b (data_out_b)
`ifdef PARITYSEL_DEMUX_STATS_EN
    ,
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .stall_seen (stall_seen)
`endif
  );

  // Record every completed output transfer at the edge where it happens.
  always @(posedge clk) begin
    if (!rst) begin
      if (a_valid && a_ready) qa.push_back(data_out_a);
      if (b_valid && b_ready) qb.push_back(data_out_b);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic [7:0] d);
    sel = s; data_in = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 4'h0; in_valid = 1'b0; data_in = 8'h00;
    a_ready = 1'b0; b_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_a_valid", a_valid, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_data_a", data_out_a, 0);
    check("rst_data_b", data_out_b, 0);
    check("rst_in_ready", in_ready, 1);

    // 1: single even beat routed to A and popped
    a_ready = 1'b1;
    sel = 4'h2; data_in = 8'hA5; in_valid = 1'b1;
    #1 check("t1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t1_a_valid", a_valid, 1);
    check("t1_data_a", data_out_a, 8'hA5);
    check("t1_b_valid", b_valid, 0);
    tick();
    check("t1_a_valid_after_pop", a_valid, 0);
    check("t1_data_a_after_pop", data_out_a, 0);

    // 2: full parity sweep with both consumers ready
    qa.delete(); qb.delete();
    a_ready = 1'b1; b_ready = 1'b1;
    for (int s = 0; s < 16; s++) push(4'(s), 8'(s));
    tick(); tick();
    check("t2_qa_size", qa.size(), 8);
    check("t2_qb_size", qb.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t2_a%0d", i), (i < qa.size()) ? qa[i] : 8'hFF, 2 * i);
      check($sformatf("t2_b%0d", i), (i < qb.size()) ? qb[i] : 8'hFF, 2 * i + 1);
    end

    // 3: B backpressure until full, A still accepts
    qa.delete(); qb.delete();
    a_ready = 1'b0; b_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 4'(2 * i + 1); data_in = 8'(8'h10 + i); in_valid = 1'b1;
      #1 check($sformatf("t3_in_ready%0d", i), in_ready, 1);
      tick();
    end
    sel = 4'h9; data_in = 8'h14;
    #1 check("t3_full_in_ready", in_ready, 0);
    tick();
    check("t3_b_head", data_out_b, 8'h10);
    sel = 4'h8;
    #1 check("t3_sel8_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t3_a_valid", a_valid, 1);
    check("t3_a_head", data_out_a, 8'h14);
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t3_qb_size", qb.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t3_b%0d", i), (i < qb.size()) ? qb[i] : 8'hFF, 8'h10 + i);
    check("t3_qa_size", qa.size(), 1);
    check("t3_b_empty", b_valid, 0);

    // 4: full A with a pop in the same cycle still refuses the push
    qa.delete(); qb.delete();
    a_ready = 1'b0; b_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'h0, 8'(8'h20 + i));
    sel = 4'h4; data_in = 8'h24; in_valid = 1'b1; a_ready = 1'b1;
    #1 check("t4_full_pop_in_ready", in_ready, 0);
    tick();
    check("t4_in_ready_next", in_ready, 1);
    check("t4_head_after_pop", data_out_a, 8'h21);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("t4_qa_size", qa.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t4_a%0d", i), (i < qa.size()) ? qa[i] : 8'hFF, 8'h20 + i);

    // 5: reset mid-stream drops stored beats
    qa.delete(); qb.delete();
    a_ready = 1'b0; b_ready = 1'b0;
    push(4'h0, 8'h30); push(4'h2, 8'h31); push(4'h4, 8'h32);
    push(4'h1, 8'h40); push(4'h3, 8'h41);
    check("t5_pre_a_valid", a_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_a_valid", a_valid, 0);
    check("t5_b_valid", b_valid, 0);
    check("t5_data_a", data_out_a, 0);
    check("t5_data_b", data_out_b, 0);
    push(4'h6, 8'h50);
    check("t5_new_head", data_out_a, 8'h50);
    check("t5_b_still_empty", b_valid, 0);
    a_ready = 1'b1;
    tick();
    check("t5_a_drained", a_valid, 0);
    check("t5_qa", (qa.size() == 1) ? qa[0] : 8'hFF, 8'h50);
    a_ready = 1'b0;

`ifdef PARITYSEL_DEMUX_STATS_EN
    // 6: stats counters, sticky stall and 16-bit wrap
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_rst_stall", stall_seen, 0);
    push(4'h0, 8'h01); push(4'h2, 8'h02); push(4'h4, 8'h03);
    push(4'h1, 8'h04); push(4'h3, 8'h05);
    check("t6_cnt_a", cnt_a, 3);
    check("t6_cnt_b", cnt_b, 2);
    check("t6_no_stall", stall_seen, 0);
    push(4'h0, 8'h06);
    push(4'h0, 8'h07);
    check("t6_stall", stall_seen, 1);
    check("t6_cnt_a_full", cnt_a, 4);
    rst = 1'b1; tick(); rst = 1'b0;
    a_ready = 1'b1; sel = 4'h0; data_in = 8'h00; in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    in_valid = 1'b0;
    check("t6_cnt_a_max", cnt_a, 16'hFFFF);
    push(4'h0, 8'h00);
    check("t6_cnt_a_wrap", cnt_a, 16'h0000);
    qa.delete();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
